// File: rtl/root_fold_n_if.sv
// Root handshake bundle for root_fold_n.
//   master : drives ST (start), MODE (operator), IN (NIN packed operands)
//   slave  : drives RD (result ready), RES (result), BUSY (fold in progress)
interface root_fold_n_if #(
    parameter int WIDTH = 16,
    parameter int NIN   = 2
) ();
    logic                 ST;
    logic [1:0]           MODE;
    logic [NIN*WIDTH-1:0] IN;
    logic                 RD;
    logic [WIDTH-1:0]     RES;
    logic                 BUSY;

    modport master (output ST, output MODE, output IN,
                    input  RD, input  RES,  input  BUSY);
    modport slave  (input  ST, input  MODE, input  IN,
                    output RD, output RES,  output BUSY);
endinterface

// File: rtl/root_fold_n.sv
// Root-level N-way fold: captures NIN operands on ST and reduces them one
// operand per clock with the selected operator (add/min/max/xor).
// Ports:
//   CLK  : rising-edge clock
//   RST  : asynchronous active-high reset
//   bus  : slave side of root_fold_n_if (ST/MODE/IN in, RD/RES/BUSY out)
//
// state | meaning
// IDLE  | no result yet, waiting for ST
// RUN   | folding captured operands, BUSY=1
// DONE  | RES valid, RD=1, ST restarts a fold
module root_fold_n #(
    parameter int WIDTH = 16,
    parameter int NIN   = 2,
    parameter int IDXW  = $clog2(NIN+1)
) (
    input  logic          CLK,
    input  logic          RST,
    root_fold_n_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [IDXW-1:0] NIN_IDX = IDXW'(NIN);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [IDXW-1:0]      idx_q, idx_d;
    logic [NIN*WIDTH-1:0] ops_q, ops_d;
    logic [1:0]           mode_q, mode_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 rd_q, rd_d;
    logic                 busy_q, busy_d;

    function automatic logic [WIDTH-1:0] fold_op(input logic [1:0]       m,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (m)
            2'b00:   r = a + b;
            2'b01:   r = (b < a) ? b : a;
            2'b10:   r = (b > a) ? b : a;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        ops_d   = ops_q;
        mode_d  = mode_q;
        res_d   = res_q;
        rd_d    = rd_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.ST) begin
                    // Operands are kept as a shift register: the word still to
                    // be folded next always sits in the low WIDTH bits.
                    acc_d   = bus.IN[WIDTH-1:0];
                    ops_d   = bus.IN >> WIDTH;
                    mode_d  = bus.MODE;
                    idx_d   = IDXW'(1);
                    rd_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (idx_q < NIN_IDX) begin
                    acc_d = fold_op(mode_q, acc_q, ops_q[WIDTH-1:0]);
                    ops_d = ops_q >> WIDTH;
                    idx_d = idx_q + 1'b1;
                end else begin
                    res_d   = acc_q;
                    rd_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            ops_q   <= '0;
            mode_q  <= '0;
            res_q   <= '0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            ops_q   <= ops_d;
            mode_q  <= mode_d;
            res_q   <= res_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.RD   = rd_q;
    assign bus.RES  = res_q;
    assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_root_fold_n.sv
// Bench for root_fold_n: a 4-operand 16-bit instance and a 1-operand 8-bit
// instance, expected results queued at capture and compared when RD rises.
module tb_root_fold_n;

    logic CLK  = 1'b0;
    logic RST4 = 1'b1;
    logic RST1 = 1'b1;

    root_fold_n_if #(.WIDTH(16), .NIN(4)) bus4 ();
    root_fold_n_if #(.WIDTH(8),  .NIN(1)) bus1 ();

    root_fold_n #(.WIDTH(16), .NIN(4)) dut4 (.CLK(CLK), .RST(RST4), .bus(bus4.slave));
    root_fold_n #(.WIDTH(8),  .NIN(1)) dut1 (.CLK(CLK), .RST(RST1), .bus(bus1.slave));

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    logic [15:0] sb4[$];
    logic [7:0]  sb1[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model4(input logic [1:0] m, input logic [63:0] v);
        logic [15:0] a;
        logic [15:0] b;
        int          sum;
        a = v[15:0];
        for (int k = 1; k < 4; k++) begin
            b = v[k*16 +: 16];
            case (m)
                2'd0: begin sum = int'(a) + int'(b); a = 16'(sum % 65536); end
                2'd1: a = (a <= b) ? a : b;
                2'd2: a = (a >= b) ? a : b;
                default: a = a ^ b;
            endcase
        end
        return a;
    endfunction

    // Drive ST for one edge with the given operands; leaves time at capture+1.
    task automatic start4(input logic [15:0] o0, input logic [15:0] o1,
                          input logic [15:0] o2, input logic [15:0] o3,
                          input logic [1:0] m, input logic [15:0] prev_res);
        @(negedge CLK);
        bus4.IN   = {o3, o2, o1, o0};
        bus4.MODE = m;
        bus4.ST   = 1'b1;
        @(posedge CLK);
        #1;
        bus4.ST = 1'b0;
        sb4.push_back(model4(m, {o3, o2, o1, o0}));
        chk("cap_busy", bus4.BUSY, 1);
        chk("cap_rd", bus4.RD, 0);
        chk("cap_res_hold", bus4.RES, prev_res);
    endtask

    // Count edges after capture until RD; optionally disturb IN/MODE/ST mid-run.
    task automatic finish4(input logic [15:0] prev_res, input bit poke);
        int          lat;
        bit          got;
        logic [15:0] exp;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 12) begin
            lat++;
            if (poke && lat == 1) begin
                @(negedge CLK);
                bus4.IN   = {4{16'hAAAA}};
                bus4.MODE = 2'b00;
                bus4.ST   = 1'b1;
            end
            @(posedge CLK);
            #1;
            if (poke && lat == 1) bus4.ST = 1'b0;
            if (bus4.RD === 1'b1) begin
                got = 1'b1;
            end else begin
                chk("run_busy", bus4.BUSY, 1);
                chk("run_res_hold", bus4.RES, prev_res);
            end
        end
        chk("rd_timeout", got, 1);
        chk("latency", lat, 4);
        exp = sb4.pop_front();
        chk("res", bus4.RES, exp);
        chk("done_busy", bus4.BUSY, 0);
    endtask

    logic [7:0] vals1 [3];

    initial begin
        bus4.ST = 1'b0; bus4.MODE = 2'b00; bus4.IN = '0;
        bus1.ST = 1'b0; bus1.MODE = 2'b00; bus1.IN = '0;
        #1;
        chk("rst_rd", bus4.RD, 0);
        chk("rst_busy", bus4.BUSY, 0);
        chk("rst_res", bus4.RES, 0);
        chk("rst1_rd", bus1.RD, 0);
        @(negedge CLK);
        RST4 = 1'b0;
        RST1 = 1'b0;

        // add with wrap, then RD held
        start4(16'h0001, 16'h0002, 16'h0003, 16'hFFFF, 2'b00, 16'h0000);
        finish4(16'h0000, 1'b0);
        chk("add_wrap", bus4.RES, 16'h0005);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            chk("hold_rd", bus4.RD, 1);
            chk("hold_res", bus4.RES, 16'h0005);
        end

        // restart from DONE: old RES kept through RUN
        start4(16'h0002, 16'h0002, 16'h0002, 16'h0002, 2'b00, 16'h0005);
        finish4(16'h0005, 1'b0);
        chk("restart_add", bus4.RES, 16'h0008);

        // min / max / xor on the same operand set
        start4(16'h0010, 16'h0003, 16'h8000, 16'h0007, 2'b01, 16'h0008);
        finish4(16'h0008, 1'b0);
        chk("min", bus4.RES, 16'h0003);
        start4(16'h0010, 16'h0003, 16'h8000, 16'h0007, 2'b10, 16'h0003);
        finish4(16'h0003, 1'b0);
        chk("max", bus4.RES, 16'h8000);
        start4(16'h0010, 16'h0003, 16'h8000, 16'h0007, 2'b11, 16'h8000);
        finish4(16'h8000, 1'b0);
        chk("xor", bus4.RES, 16'h8014);

        // IN/MODE/ST disturbed during RUN have no effect
        start4(16'h0005, 16'h0009, 16'h0007, 16'h0001, 2'b10, 16'h8014);
        finish4(16'h8014, 1'b1);
        chk("ignore_run", bus4.RES, 16'h0009);

        // async reset in the 2nd RUN cycle
        start4(16'h0007, 16'h0008, 16'h0009, 16'h000A, 2'b00, 16'h0009);
        @(posedge CLK); #3;
        RST4 = 1'b1;
        #1;
        chk("arst_rd", bus4.RD, 0);
        chk("arst_busy", bus4.BUSY, 0);
        chk("arst_res", bus4.RES, 0);
        void'(sb4.pop_back());
        @(negedge CLK);
        RST4 = 1'b0;
        start4(16'h0001, 16'h0001, 16'h0001, 16'h0001, 2'b00, 16'h0000);
        finish4(16'h0000, 1'b0);
        chk("post_rst", bus4.RES, 16'h0004);

        // NIN=1 with ST held high: capture / DONE alternate
        vals1[0] = 8'h5A; vals1[1] = 8'h3C; vals1[2] = 8'hC3;
        @(negedge CLK);
        bus1.MODE = 2'b11;
        bus1.ST   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus1.IN = vals1[i];
            @(posedge CLK); #1;
            sb1.push_back(vals1[i]);
            chk("n1_cap_busy", bus1.BUSY, 1);
            chk("n1_cap_rd", bus1.RD, 0);
            chk("n1_cap_res", bus1.RES, (i == 0) ? 8'h00 : vals1[i-1]);
            @(negedge CLK);
            bus1.IN = ~vals1[i];
            @(posedge CLK); #1;
            chk("n1_rd", bus1.RD, 1);
            chk("n1_busy", bus1.BUSY, 0);
            chk("n1_res", bus1.RES, sb1.pop_front());
            @(negedge CLK);
        end
        bus1.ST = 1'b0;
        @(posedge CLK); #1;
        chk("n1_hold_rd", bus1.RD, 1);
        chk("n1_hold_res", bus1.RES, 8'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
